// File: rtl/mmio_bridge.sv
// Memory-stage MMIO bridge: RAM pass-through, output FIFO at IO_BASE+0, input holding register at IO_BASE+2.
// Define MMIO_STATUS_REG_EN to map {in_full, fifo_full, fifo_empty} at IO_BASE+4; stall holds a store to a full FIFO.
module mmio_bridge #(
  parameter logic [15:0] IO_BASE    = 16'hFF00,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_write,
  input  logic        mem_read,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        stall,
  output logic        ram_we,
  output logic [15:0] ram_addr,
  output logic [15:0] ram_wdata,
  input  logic [15:0] ram_rdata,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ack
);

  localparam int PtrW = $clog2(FIFO_DEPTH);

  logic [15:0]     fifoMem [FIFO_DEPTH];
  logic [PtrW-1:0] wrPtr;
  logic [PtrW-1:0] rdPtr;
  logic [PtrW:0]   count;
  logic            fifoFull;
  logic            fifoEmpty;
  logic            push;
  logic            pop;

  logic [15:0]     holdReg;
  logic            inFull;
  logic            capture;
  logic            readIn;

  logic            isIo;
  logic            isOutAddr;
  logic            isInAddr;
  logic            ioLoad;
  logic            storeOut;

  assign isIo      = addr >= IO_BASE;
  assign isOutAddr = isIo && (addr == IO_BASE);
  assign isInAddr  = isIo && (addr == IO_BASE + 16'd2);
  // A combined read+write on I/O is treated as a write only.
  assign ioLoad    = isIo && mem_read && !mem_write;
  assign storeOut  = isOutAddr && mem_write;

  assign ram_we    = mem_write && !isIo;
  assign ram_addr  = addr;
  assign ram_wdata = wdata;

  // Count reaches exactly FIFO_DEPTH (a power of two) only when full.
  assign fifoFull  = count[PtrW];
  assign fifoEmpty = (count == '0);
  assign push      = storeOut && !fifoFull;
  assign stall     = storeOut && fifoFull;
  assign pop       = !fifoEmpty && out_ready;
  assign out_valid = !fifoEmpty;
  assign out_data  = fifoMem[rdPtr];

  assign capture   = in_valid && !inFull;
  assign readIn    = ioLoad && isInAddr;

`ifdef MMIO_STATUS_REG_EN
  logic isStatAddr;
  assign isStatAddr = isIo && (addr == IO_BASE + 16'd4);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifoMem[i] <= '0;
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        fifoMem[wrPtr] <= wdata;
        wrPtr          <= wrPtr + 1'b1;
      end
      if (pop) rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A load racing a capture into an empty register sees 0 and the capture wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      holdReg <= '0;
      inFull  <= 1'b0;
      in_ack  <= 1'b0;
    end else begin
      in_ack <= capture;
      if (capture) begin
        holdReg <= in_data;
        inFull  <= 1'b1;
      end else if (readIn) begin
        inFull  <= 1'b0;
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (!isIo) begin
      rdata = ram_rdata;
    end else if (readIn) begin
      rdata = inFull ? holdReg : 16'h0000;
    end
`ifdef MMIO_STATUS_REG_EN
    else if (ioLoad && isStatAddr) begin
      rdata = {13'b0, inFull, fifoFull, fifoEmpty};
    end
`endif
  end

endmodule

// File: tb/tb_mmio_bridge.sv
// Directed bench for mmio_bridge: RAM pass-through, output FIFO, input holding register, reset.
module tb_mmio_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_write, mem_read;
  logic [15:0] addr, wdata, rdata;
  logic        stall, ram_we;
  logic [15:0] ram_addr, ram_wdata, ram_rdata;
  logic [15:0] out_data;
  logic        out_valid, out_ready;
  logic [15:0] in_data;
  logic        in_valid, in_ack;

  int checks = 0;
  int errors = 0;

  logic [15:0] ram [256];

  always #5 clk = ~clk;

  assign ram_rdata = ram[ram_addr[7:0]];
  always @(posedge clk) if (ram_we) ram[ram_addr[7:0]] <= ram_wdata;

  mmio_bridge dut (
    .clk(clk), .reset(reset), .mem_write(mem_write), .mem_read(mem_read),
    .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .in_data(in_data), .in_valid(in_valid), .in_ack(in_ack)
  );

  task automatic idle();
    mem_write = 1'b0; mem_read = 1'b0; addr = 16'h0000; wdata = 16'h0000;
  endtask

  task automatic test_reset();
    reset = 1'b1; idle(); out_ready = 1'b0; in_data = 16'h0; in_valid = 1'b0;
    for (int i = 0; i < 256; i++) ram[i] = 16'h0;
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL reset_out_data got %h want 0000", out_data); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
    checks++; if (in_ack !== 1'b0) begin errors++; $display("FAIL reset_in_ack got %b want 0", in_ack); end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_ram_passthrough();
    @(negedge clk); mem_write = 1'b1; addr = 16'h0010; wdata = 16'h1234; #1;
    checks++; if (ram_we !== 1'b1) begin errors++; $display("FAIL ram_we_store got %b want 1", ram_we); end
    checks++; if (ram_addr !== 16'h0010 || ram_wdata !== 16'h1234) begin errors++; $display("FAIL ram_mirror got %h/%h want 0010/1234", ram_addr, ram_wdata); end
    @(negedge clk); mem_write = 1'b0; mem_read = 1'b1; #1;
    checks++; if (rdata !== 16'h1234) begin errors++; $display("FAIL ram_load got %h want 1234", rdata); end
    @(negedge clk); mem_read = 1'b0; mem_write = 1'b1; addr = 16'hFF06; wdata = 16'h5555; #1;
    checks++; if (ram_we !== 1'b0 || ram_addr !== 16'hFF06 || ram_wdata !== 16'h5555) begin errors++; $display("FAIL io_ram_we got we=%b addr=%h data=%h want 0/FF06/5555", ram_we, ram_addr, ram_wdata); end
    @(posedge clk); #1; idle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL unmapped_store got out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_fifo_fill();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); mem_write = 1'b1; addr = 16'hFF00; wdata = 16'hA000 + 16'(i); #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fill_stall_%0d got %b want 0", i, stall); end
      if (i == 0) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL no_bypass got %b want 0", out_valid); end
      end
      @(posedge clk); #1;
    end
    @(negedge clk); wdata = 16'hA004; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL full_stall got %b want 1", stall); end
    checks++; if (out_valid !== 1'b1 || out_data !== 16'hA000) begin errors++; $display("FAIL full_head got %b/%h want 1/A000", out_valid, out_data); end
  endtask

  task automatic test_stall_release();
    @(negedge clk); out_ready = 1'b1; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL pop_cycle_stall got %b want 1", stall); end
    @(posedge clk); #1;
    checks++; if (stall !== 1'b0 || out_data !== 16'hA001) begin errors++; $display("FAIL after_pop got stall=%b head=%h want 0/A001", stall, out_data); end
    @(negedge clk); out_ready = 1'b0;
    @(posedge clk); #1; idle();
    for (int j = 1; j < 5; j++) begin
      @(negedge clk); out_ready = 1'b1; #1;
      checks++; if (out_valid !== 1'b1 || out_data !== 16'hA000 + 16'(j)) begin errors++; $display("FAIL drain_%0d got %b/%h want 1/%h", j, out_valid, out_data, 16'hA000 + 16'(j)); end
    end
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drained got %b want 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); mem_write = 1'b1; addr = 16'hFF00; wdata = 16'hB000 + 16'(i);
    end
    @(negedge clk); wdata = 16'hB002; out_ready = 1'b1; #1;
    checks++; if (out_data !== 16'hB000 || stall !== 1'b0) begin errors++; $display("FAIL b2b_head0 got %h/%b want B000/0", out_data, stall); end
    @(negedge clk); idle(); #1;
    checks++; if (out_data !== 16'hB001) begin errors++; $display("FAIL b2b_head1 got %h want B001", out_data); end
    @(negedge clk); #1;
    checks++; if (out_data !== 16'hB002 || out_valid !== 1'b1) begin errors++; $display("FAIL b2b_head2 got %h/%b want B002/1", out_data, out_valid); end
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got %b want 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_input_port();
    @(negedge clk); in_data = 16'hBEEF; in_valid = 1'b1; #1;
    checks++; if (in_ack !== 1'b0) begin errors++; $display("FAIL ack_early got %b want 0", in_ack); end
    @(posedge clk); #1;
    checks++; if (in_ack !== 1'b1) begin errors++; $display("FAIL ack_pulse got %b want 1", in_ack); end
    in_data = 16'h1111;
    @(posedge clk); #1;
    checks++; if (in_ack !== 1'b0) begin errors++; $display("FAIL ack_single got %b want 0", in_ack); end
    in_valid = 1'b0;
    @(negedge clk); mem_read = 1'b1; addr = 16'hFF02; #1;
    checks++; if (rdata !== 16'hBEEF) begin errors++; $display("FAIL hold_load got %h want BEEF", rdata); end
    @(negedge clk); #1;
    checks++; if (rdata !== 16'h0000) begin errors++; $display("FAIL hold_reload got %h want 0000", rdata); end
    @(negedge clk); in_valid = 1'b1; in_data = 16'hCAFE; #1;
    checks++; if (rdata !== 16'h0000) begin errors++; $display("FAIL race_load got %h want 0000", rdata); end
    @(posedge clk); #1; in_valid = 1'b0;
    checks++; if (in_ack !== 1'b1) begin errors++; $display("FAIL race_ack got %b want 1", in_ack); end
    @(negedge clk); #1;
    checks++; if (rdata !== 16'hCAFE) begin errors++; $display("FAIL race_value got %h want CAFE", rdata); end
    @(negedge clk); idle();
  endtask

  task automatic test_unmapped();
    @(negedge clk); addr = 16'hFF06; mem_read = 1'b1; #1;
    checks++; if (rdata !== 16'h0000) begin errors++; $display("FAIL unmapped_load got %h want 0000", rdata); end
    ram[0] = 16'h7777;
    mem_read = 1'b0; addr = 16'hFF00; #1;
    checks++; if (rdata !== 16'h0000) begin errors++; $display("FAIL io_noread got %h want 0000", rdata); end
    mem_read = 1'b1; mem_write = 1'b1; wdata = 16'hD00D; #1;
    checks++; if (rdata !== 16'h0000) begin errors++; $display("FAIL rw_rdata got %h want 0000", rdata); end
    @(negedge clk); idle(); #1;
    checks++; if (out_valid !== 1'b1 || out_data !== 16'hD00D) begin errors++; $display("FAIL rw_write got %b/%h want 1/D00D", out_valid, out_data); end
    out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
  endtask

  task automatic test_reset_midstream();
    logic [15:0] statExp;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); mem_write = 1'b1; addr = 16'hFF00; wdata = 16'hC000 + 16'(i);
    end
    @(negedge clk); idle(); #2; reset = 1'b1; #1;
    checks++; if (out_valid !== 1'b0 || stall !== 1'b0 || out_data !== 16'h0000) begin errors++; $display("FAIL rst_mid got v=%b s=%b d=%h want 0/0/0000", out_valid, stall, out_data); end
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); mem_write = 1'b1; addr = 16'hFF00; wdata = 16'hE000 + 16'(i);
    end
    @(negedge clk); wdata = 16'hE004; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rst_pre_stall got %b want 1", stall); end
    #2; reset = 1'b1; #1;
    checks++; if (stall !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL rst_stall got s=%b v=%b want 0/0", stall, out_valid); end
    @(negedge clk); reset = 1'b0; idle();
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_discard got %b want 0", out_valid); end
`ifdef MMIO_STATUS_REG_EN
    statExp = 16'h0001;
`else
    statExp = 16'h0000;
`endif
    @(negedge clk); mem_read = 1'b1; addr = 16'hFF04; #1;
    checks++; if (rdata !== statExp) begin errors++; $display("FAIL status_load got %h want %h", rdata, statExp); end
    @(negedge clk); idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_ram_passthrough();
    test_fifo_fill();
    test_stall_release();
    test_back_to_back();
    test_input_port();
    test_unmapped();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
